// File: rtl/core_pipe_ctrl.sv
// Pipeline control FSM: redirect/flush sequencing after a taken jump, and
// stall handling for execute/bus hold requests with a bounded hold window.
module core_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_MAX     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  input  logic        hold_flag_in,
  input  logic        bus_hold_req_in,
  output logic        pc_we_out,
  output logic [31:0] pc_addr_out,
  output logic        flush_if_id_out,
  output logic        flush_id_ex_out,
  output logic        stall_pc_out,
  output logic        stall_if_id_out,
  output logic        stall_id_ex_out,
  output logic        hold_timeout_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_MAX - 1);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  bubble_cnt_r;
  logic [3:0]  bubble_cnt_s;
  logic [7:0]  hold_cnt_r;
  logic [7:0]  hold_cnt_s;
  logic [31:0] target_s;
  logic        timeout_s;
  logic        hold_req_s;
  logic        pc_we_s;
  logic        flush_s;
  logic        stall_s;

  assign hold_req_s = hold_flag_in | bus_hold_req_in;
  assign state_out  = state_r;

  // Next-state, counter and latched-target logic; outputs decoded from the next state
  always_comb begin
    state_s      = state_r;
    bubble_cnt_s = bubble_cnt_r;
    hold_cnt_s   = hold_cnt_r;
    target_s     = pc_addr_out;
    timeout_s    = hold_timeout_out;
    case (state_r)
      ST_RUN: begin
        if (jump_flag_in) begin
          state_s  = ST_REDIRECT;
          target_s = jump_addr_in;
        end else if (hold_req_s) begin
          state_s    = ST_HOLD;
          hold_cnt_s = 8'd0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        state_s      = ST_FLUSH;
        bubble_cnt_s = FLUSH_INIT;
      end
      ST_FLUSH: begin
        // Jump and execute hold come from flushed-path instructions; only the bus matters here
        bubble_cnt_s = (bubble_cnt_r == 4'd0) ? 4'd0 : (bubble_cnt_r - 4'd1);
        if (bubble_cnt_r <= 4'd1) begin
          if (bus_hold_req_in) begin
            state_s    = ST_HOLD;
            hold_cnt_s = 8'd0;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_HOLD: begin
        if (!hold_req_s) begin
          if (jump_flag_in) begin
            state_s  = ST_REDIRECT;
            target_s = jump_addr_in;
          end else begin
            state_s = ST_RUN;
          end
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s   = ST_RUN;
          timeout_s = 1'b1;
        end else begin
          state_s    = ST_HOLD;
          hold_cnt_s = hold_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase

    pc_we_s = (state_s == ST_REDIRECT);
    flush_s = (state_s == ST_REDIRECT) || (state_s == ST_FLUSH);
    stall_s = (state_s == ST_HOLD);
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= ST_RUN;
      bubble_cnt_r     <= 4'd0;
      hold_cnt_r       <= 8'd0;
      pc_we_out        <= 1'b0;
      pc_addr_out      <= 32'h0000_0000;
      flush_if_id_out  <= 1'b0;
      flush_id_ex_out  <= 1'b0;
      stall_pc_out     <= 1'b0;
      stall_if_id_out  <= 1'b0;
      stall_id_ex_out  <= 1'b0;
      hold_timeout_out <= 1'b0;
    end else begin
      state_r          <= state_s;
      bubble_cnt_r     <= bubble_cnt_s;
      hold_cnt_r       <= hold_cnt_s;
      pc_we_out        <= pc_we_s;
      pc_addr_out      <= target_s;
      flush_if_id_out  <= flush_s;
      flush_id_ex_out  <= flush_s;
      stall_pc_out     <= stall_s;
      stall_if_id_out  <= stall_s;
      stall_id_ex_out  <= stall_s;
      hold_timeout_out <= timeout_s;
    end
  end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Self-checking bench for core_pipe_ctrl: directed scenarios plus randomized
// traffic compared against a mode/remaining-cycles reference model.
module tb_core_pipe_ctrl;

  localparam int FC = 2;
  localparam int HM = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jf  = 1'b0;
  logic [31:0] ja  = 32'h0;
  logic        hf  = 1'b0;
  logic        bf  = 1'b0;
  logic        pc_we;
  logic [31:0] pc_addr;
  logic        fl_ifid, fl_idex, st_pc, st_ifid, st_idex, tmo;
  logic [1:0]  st;

  int n_vec = 0;
  int n_err = 0;

  // reference model: mode 0=RUN 1=REDIRECT 2=FLUSH 3=HOLD
  int          m_mode;
  int          m_left;
  int          m_served;
  logic [31:0] m_pc;
  logic        m_to;

  core_pipe_ctrl #(.FLUSH_CYCLES(FC), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_in(jf), .jump_addr_in(ja),
    .hold_flag_in(hf), .bus_hold_req_in(bf),
    .pc_we_out(pc_we), .pc_addr_out(pc_addr),
    .flush_if_id_out(fl_ifid), .flush_id_ex_out(fl_idex),
    .stall_pc_out(st_pc), .stall_if_id_out(st_ifid), .stall_id_ex_out(st_idex),
    .hold_timeout_out(tmo), .state_out(st)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_served = 0; m_pc = 32'h0; m_to = 1'b0;
  endtask

  task automatic model_edge();
    case (m_mode)
      0: if (jf) begin m_mode = 1; m_pc = ja; end
         else if (hf || bf) begin m_mode = 3; m_served = 1; end
      1: begin m_mode = 2; m_left = FC; end
      2: if (m_left <= 1) begin
           m_left = 0;
           if (bf) begin m_mode = 3; m_served = 1; end else m_mode = 0;
         end else m_left = m_left - 1;
      default: if (!(hf || bf)) begin
                 if (jf) begin m_mode = 1; m_pc = ja; end else m_mode = 0;
               end else if (m_served == HM) begin
                 m_to = 1'b1; m_mode = 0;
               end else m_served = m_served + 1;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset(); else model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    n_vec++;
    if ({pc_we, fl_ifid, fl_idex, st_pc, st_ifid, st_idex, tmo} !== 7'b0 || pc_addr !== 32'h0 || st !== 2'd0) begin
      n_err++; $display("FAIL reset_vals: got we=%b fl=%b%b stl=%b%b%b to=%b pc=%h st=%0d expected all zero",
                        pc_we, fl_ifid, fl_idex, st_pc, st_ifid, st_idex, tmo, pc_addr, st);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if (st !== 2'd0) begin n_err++; $display("FAIL reset_release: state %0d expected 0", st); end
  endtask

  task automatic test_redirect();
    jf = 1'b1; ja = 32'h100; step(); jf = 1'b0;
    n_vec++;
    if (st !== 2'd1 || pc_we !== 1'b1 || pc_addr !== 32'h100 || fl_ifid !== 1'b1 || fl_idex !== 1'b1) begin
      n_err++; $display("FAIL redirect: st=%0d we=%b pc=%h fl=%b%b expected st=1 we=1 pc=100 fl=11", st, pc_we, pc_addr, fl_ifid, fl_idex);
    end
    step();
    n_vec++;
    if (st !== 2'd2 || pc_we !== 1'b0 || fl_ifid !== 1'b1 || fl_idex !== 1'b1) begin
      n_err++; $display("FAIL flush1: st=%0d we=%b fl=%b%b expected st=2 we=0 fl=11", st, pc_we, fl_ifid, fl_idex);
    end
    jf = 1'b1; ja = 32'h200; hf = 1'b1; step(); jf = 1'b0; hf = 1'b0;
    n_vec++;
    if (st !== 2'd2 || pc_addr !== 32'h100 || pc_we !== 1'b0) begin
      n_err++; $display("FAIL flush2_ignore_jump: st=%0d pc=%h we=%b expected st=2 pc=100 we=0", st, pc_addr, pc_we);
    end
    step();
    n_vec++;
    if (st !== 2'd0 || fl_ifid !== 1'b0 || pc_addr !== 32'h100) begin
      n_err++; $display("FAIL flush_exit: st=%0d fl=%b pc=%h expected st=0 fl=0 pc=100", st, fl_ifid, pc_addr);
    end
    step();
    n_vec++;
    if (st !== 2'd0 || pc_we !== 1'b0) begin
      n_err++; $display("FAIL no_second_redirect: st=%0d we=%b expected st=0 we=0", st, pc_we);
    end
  endtask

  task automatic test_jump_priority();
    logic [31:0] a;
    a = $urandom;
    jf = 1'b1; hf = 1'b1; ja = a; step(); jf = 1'b0; hf = 1'b0;
    n_vec++;
    if (st !== 2'd1 || st_pc !== 1'b0 || pc_addr !== a) begin
      n_err++; $display("FAIL jump_priority: st=%0d stall=%b pc=%h expected st=1 stall=0 pc=%h", st, st_pc, pc_addr, a);
    end
    for (int i = 0; i < 3; i++) step();
    n_vec++;
    if (st !== 2'd0) begin n_err++; $display("FAIL jump_priority_ret: st=%0d expected 0", st); end
  endtask

  task automatic test_bus_hold();
    bf = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (st !== 2'd3 || {st_pc, st_ifid, st_idex} !== 3'b111 || fl_ifid !== 1'b0) begin
        n_err++; $display("FAIL bus_hold[%0d]: st=%0d stalls=%b%b%b fl=%b expected st=3 stalls=111 fl=0", i, st, st_pc, st_ifid, st_idex, fl_ifid);
      end
    end
    bf = 1'b0; step();
    n_vec++;
    if (st !== 2'd0 || {st_pc, st_ifid, st_idex} !== 3'b000 || tmo !== 1'b0) begin
      n_err++; $display("FAIL bus_hold_end: st=%0d stalls=%b%b%b to=%b expected st=0 stalls=000 to=0", st, st_pc, st_ifid, st_idex, tmo);
    end
  endtask

  task automatic test_timeout();
    bf = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] es;
      logic       et;
      step();
      es = (i == HM) ? 2'd0 : 2'd3;
      et = (i >= HM) ? 1'b1 : 1'b0;
      n_vec++;
      if (st !== es || tmo !== et) begin
        n_err++; $display("FAIL timeout[%0d]: st=%0d to=%b expected st=%0d to=%b", i, st, tmo, es, et);
      end
    end
    bf = 1'b0; step();
    n_vec++;
    if (st !== 2'd0 || tmo !== 1'b1) begin
      n_err++; $display("FAIL timeout_sticky: st=%0d to=%b expected st=0 to=1", st, tmo);
    end
  endtask

  task automatic test_async_reset();
    jf = 1'b1; ja = 32'h300; step(); jf = 1'b0; step();
    n_vec++;
    if (st !== 2'd2) begin n_err++; $display("FAIL pre_reset_flush: st=%0d expected 2", st); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({pc_we, fl_ifid, fl_idex, st_pc, st_ifid, st_idex, tmo} !== 7'b0 || pc_addr !== 32'h0 || st !== 2'd0) begin
      n_err++; $display("FAIL async_reset: got we=%b fl=%b%b to=%b pc=%h st=%0d expected all zero", pc_we, fl_ifid, fl_idex, tmo, pc_addr, st);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    n_vec++;
    if (st !== 2'd0 || fl_ifid !== 1'b0 || pc_addr !== 32'h0 || tmo !== 1'b0) begin
      n_err++; $display("FAIL post_reset: st=%0d fl=%b pc=%h to=%b expected st=0 fl=0 pc=0 to=0", st, fl_ifid, pc_addr, tmo);
    end
    jf = 1'b1; ja = 32'h400; step(); jf = 1'b0;
    n_vec++;
    if (st !== 2'd1 || pc_we !== 1'b1 || pc_addr !== 32'h400) begin
      n_err++; $display("FAIL post_reset_redirect: st=%0d we=%b pc=%h expected st=1 we=1 pc=400", st, pc_we, pc_addr);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      logic [1:0] es;
      jf = ($urandom_range(5) == 0);
      hf = ($urandom_range(4) == 0);
      bf = ($urandom_range(3) == 0);
      ja = $urandom;
      step();
      es = 2'(m_mode);
      n_vec++;
      if (st !== es || pc_we !== (m_mode == 1) || pc_addr !== m_pc || tmo !== m_to ||
          fl_ifid !== (m_mode == 1 || m_mode == 2) || fl_idex !== (m_mode == 1 || m_mode == 2) ||
          {st_pc, st_ifid, st_idex} !== {3{m_mode == 3}}) begin
        n_err++; $display("FAIL random[%0d]: st=%0d we=%b pc=%h to=%b fl=%b%b stl=%b%b%b expected st=%0d pc=%h to=%b",
                          i, st, pc_we, pc_addr, tmo, fl_ifid, fl_idex, st_pc, st_ifid, st_idex, es, m_pc, m_to);
      end
      n_vec++;
      if ((fl_ifid | fl_idex) & (st_pc | st_ifid | st_idex)) begin
        n_err++; $display("FAIL flush_stall_overlap[%0d]: fl=%b%b stl=%b%b%b expected no overlap", i, fl_ifid, fl_idex, st_pc, st_ifid, st_idex);
      end
    end
    jf = 1'b0; hf = 1'b0; bf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_jump_priority();
    test_bus_hold();
    test_timeout();
    test_async_reset();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
